// File: rtl/accum_display.sv
// accum_display: converts an 8-bit accumulator value to BCD with a
// sequential double-dabble engine, then drives a 4-digit multiplexed
// 7-segment display (active-low segments and digit enables) with
// leading-zero blanking.
module accum_display #(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       CLR,
  input  logic [7:0] VAL,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [REFRESH_BITS-1:0] REFRESH_ONE  = 1;
  localparam logic [REFRESH_BITS-1:0] REFRESH_LAST = '1;
  localparam logic [6:0]              SEG_BLANK    = 7'h7F;
  localparam logic [6:0]              SEG_ZERO     = 7'h40;

  // Converter state
  state_t      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  last_q, last_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  iter_q, iter_d;

  // Display registers, only ever written from LATCH
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  // Refresh / multiplexing state
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]  digit_q, digit_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  // Double-dabble step helpers
  logic [11:0] bcd_adj;
  logic [19:0] shifted;

  // Add 3 to a BCD nibble that would overflow past 9 once doubled
  function automatic logic [3:0] bcd_adjust(input logic [3:0] n);
    bcd_adjust = (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Active-low segment pattern for one decimal digit (gfedcba)
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'h40;
      4'd1:    seg_encode = 7'h79;
      4'd2:    seg_encode = 7'h24;
      4'd3:    seg_encode = 7'h30;
      4'd4:    seg_encode = 7'h19;
      4'd5:    seg_encode = 7'h12;
      4'd6:    seg_encode = 7'h02;
      4'd7:    seg_encode = 7'h78;
      4'd8:    seg_encode = 7'h00;
      4'd9:    seg_encode = 7'h10;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble iteration: correct each nibble, then shift {bcd, bin} left
  always_comb begin
    bcd_adj = {bcd_adjust(bcd_q[11:8]), bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Converter FSM next-state and datapath; VAL is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    cap_d   = cap_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (VAL != last_q) begin
          bin_d   = VAL;
          cap_d   = VAL;
          bcd_d   = 12'd0;
          iter_d  = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d  = shifted[19:8];
        bin_d  = shifted[7:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        last_d  = cap_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Converter and display registers; CLR aborts any conversion in flight
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      bin_q   <= 8'd0;
      cap_q   <= 8'd0;
      last_q  <= 8'd0;
      bcd_q   <= 12'd0;
      iter_q  <= 3'd0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  // Refresh counter, digit rotation and the registered segment/anode drive
  always_comb begin
    refresh_d = refresh_q + REFRESH_ONE;
    digit_d   = digit_q;
    if (refresh_q == REFRESH_LAST) begin
      digit_d = digit_q + 2'd1;
    end
    an_d  = ~(4'b0001 << digit_d);
    seg_d = SEG_BLANK;
    case (digit_d)
      2'd0: seg_d = seg_encode(ones_q);
      2'd1: seg_d = ((hund_q == 4'd0) && (tens_q == 4'd0)) ? SEG_BLANK : seg_encode(tens_q);
      2'd2: seg_d = (hund_q == 4'd0) ? SEG_BLANK : seg_encode(hund_q);
      default: seg_d = SEG_BLANK;
    endcase
  end

  // Display scan registers; reset value shows a single "0" on the ones digit
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      refresh_q <= '0;
      digit_q   <= 2'd0;
      seg_q     <= SEG_ZERO;
      an_q      <= 4'b1110;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_accum_display.sv
// Testbench for accum_display: scoreboard of converted values, checked
// against the latched BCD digits and the multiplexed segment output.
module tb_accum_display;

  logic       clk;
  logic       CLR;
  logic [7:0] VAL;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       BUSY;

  int pass_count  = 0;
  int check_count = 0;
  int exp_q[$];

  accum_display #(.REFRESH_BITS(2)) dut (
    .clk  (clk),
    .CLR  (CLR),
    .VAL  (VAL),
    .SEG  (SEG),
    .AN   (AN),
    .BUSY (BUSY)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'h40; 1: enc = 7'h79; 2: enc = 7'h24; 3: enc = 7'h30; 4: enc = 7'h19;
      5: enc = 7'h12; 6: enc = 7'h02; 7: enc = 7'h78; 8: enc = 7'h00; 9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] exp_bcd(input int v);
    exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expected {digit3, digit2, digit1, digit0} segment patterns
  function automatic logic [27:0] exp_segs(input int v);
    int h, t, o;
    logic [6:0] d2, d1;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    d2 = (h == 0) ? 7'h7F : enc(h);
    d1 = (h == 0 && t == 0) ? 7'h7F : enc(t);
    exp_segs = {7'h7F, d2, d1, enc(o)};
  endfunction

  task automatic applyStimulus(input int v);
    @(negedge clk);
    VAL = 8'(v);
    exp_q.push_back(v);
  endtask

  task automatic wait_busy_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("busy_rise_timeout", 32'd0, 32'd1);
  endtask

  // Follow one conversion to its LATCH and compare the BCD with the scoreboard
  task automatic await_latch(input bit check_len);
    bit ok;
    bit done;
    int cnt;
    int v;
    wait_busy_high(ok);
    if (!ok) return;
    cnt  = 1;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!BUSY) begin
        done = 1'b1;
        break;
      end
      cnt++;
    end
    if (!done) begin
      checkOutput("busy_fall_timeout", 32'd0, 32'd1);
      return;
    end
    if (check_len) checkOutput("busy_len", 32'(cnt), 32'd9);
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    v = exp_q.pop_front();
    checkOutput($sformatf("bcd_%0d", v), {20'd0, dut.hund_q, dut.tens_q, dut.ones_q}, {20'd0, exp_bcd(v)});
  endtask

  // Watch one full digit rotation and rebuild the four displayed patterns
  task automatic scan_display(input int v);
    logic [27:0] segs;
    int bad_an;
    segs   = '0;
    bad_an = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (AN)
        4'b1110: segs[6:0]   = SEG;
        4'b1101: segs[13:7]  = SEG;
        4'b1011: segs[20:14] = SEG;
        4'b0111: segs[27:21] = SEG;
        default: bad_an++;
      endcase
    end
    checkOutput("an_onehot", 32'(bad_an), 32'd0);
    checkOutput($sformatf("segs_%0d", v), {4'd0, segs}, {4'd0, exp_segs(v)});
  endtask

  initial begin
    bit ok;
    CLR = 1'b1;
    VAL = 8'd0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("reset_an",   {28'd0, AN},   32'hE);
    checkOutput("reset_seg",  {25'd0, SEG},  32'h40);

    $display("[TB] idle rotation with VAL=0");
    CLR = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) #1;
      else @(negedge clk);
      checkOutput($sformatf("rot_an_%0d", k), {28'd0, AN}, {28'd0, ~(4'b0001 << ((k / 4) % 4))});
      checkOutput($sformatf("rot_seg_%0d", k), {25'd0, SEG}, ((k / 4) % 4 == 0) ? 32'h40 : 32'h7F);
      checkOutput($sformatf("rot_busy_%0d", k), {31'd0, BUSY}, 32'd0);
    end

    $display("[TB] single conversions");
    applyStimulus(255); await_latch(1'b1); scan_display(255);
    applyStimulus(7);   await_latch(1'b1); scan_display(7);
    applyStimulus(40);  await_latch(1'b1); scan_display(40);

    $display("[TB] value change during conversion");
    applyStimulus(100);
    wait_busy_high(ok);
    @(negedge clk);
    applyStimulus(101);
    await_latch(1'b0);
    checkOutput("idle_gap_low", {31'd0, BUSY}, 32'd0);
    @(negedge clk);
    checkOutput("idle_gap_rise", {31'd0, BUSY}, 32'd1);
    await_latch(1'b0);
    scan_display(101);

    $display("[TB] reset mid-conversion");
    applyStimulus(200);
    wait_busy_high(ok);
    repeat (4) @(negedge clk);
    CLR = 1'b1;
    #1;
    checkOutput("clr_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("clr_seg",  {25'd0, SEG},  32'h40);
    checkOutput("clr_an",   {28'd0, AN},   32'hE);
    checkOutput("clr_disp", {20'd0, dut.hund_q, dut.tens_q, dut.ones_q}, 32'd0);
    repeat (2) @(negedge clk);
    CLR = 1'b0;
    await_latch(1'b1);
    scan_display(200);

    $display("[TB] sweep 0..255");
    for (int v = 0; v < 256; v++) begin
      applyStimulus(v);
      await_latch(1'b1);
    end
    scan_display(255);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/accum_display.md
ACCUM_DISPLAY -- requirements
Module: accum_display

Interface
REQ-001 Parameter: REFRESH_BITS, default 16, width of the free-running refresh counter; the active digit advances every 2^REFRESH_BITS clk cycles.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 CLR  input  1  reset, asynchronous, active-high; forces all state to reset values immediately.
REQ-004 VAL  input  8  unsigned binary value to display, sourced from the accumulator output.
REQ-005 SEG  output  7  segment drive, active-low, SEG[0]=a ... SEG[6]=g.
REQ-006 AN  output  4  digit enables, active-low, AN[0]=ones ... AN[3]=thousands.
REQ-007 BUSY  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-008 Converter SHALL be an FSM with states IDLE, SHIFT, LATCH.
REQ-009 IDLE: if VAL != LAST (last converted value), SHALL capture VAL into shift register, clear 12-bit BCD scratch, clear iteration count, go to SHIFT; else stay IDLE.
REQ-010 SHIFT: each cycle SHALL add 3 to every BCD nibble >= 5, then shift {BCD, bin} left one bit; after the 8th iteration go to LATCH.
REQ-011 LATCH: SHALL copy BCD scratch into display registers HUND/TENS/ONES, set LAST to the captured value, go to IDLE.
REQ-012 Latency: display registers SHALL hold the new value on the 10th rising edge after the edge on which IDLE detects the change (1 capture + 8 shift + 1 latch).
REQ-013 BUSY SHALL be high in SHIFT and LATCH, low in IDLE.
REQ-014 VAL changes during SHIFT/LATCH SHALL be ignored; the comparison in the following IDLE cycle triggers a fresh conversion, so the final display always matches the last stable VAL.
REQ-015 Display registers SHALL change only in LATCH; no partial result ever reaches SEG.
REQ-016 Refresh counter SHALL increment every cycle and wrap at 2^REFRESH_BITS; on wrap the 2-bit digit index SHALL increment modulo 4 (0->1->2->3->0).
REQ-017 AN SHALL have exactly one bit low, the bit selected by digit index.
REQ-018 Digit 3 SHALL always be blank (SEG = 7'h7F), since VAL max is 255.
REQ-019 Leading-zero blanking: digit 2 blank when HUND=0; digit 1 blank when HUND=0 and TENS=0; digit 0 never blank.
REQ-020 Non-blank digits SHALL use standard 0-9 encodings, active-low (e.g. 0 -> 7'h40, 1 -> 7'h79, 5 -> 7'h12, 8 -> 7'h00).
REQ-021 SEG and AN SHALL be registered, updating on the same edge as the digit index.
REQ-022 BCD nibbles SHALL never exceed 9; max result 2-5-5.

Reset
REQ-023 While CLR is high: state IDLE, LAST=0, HUND=TENS=ONES=0, counter=0, digit index=0, BUSY=0, AN=4'b1110, SEG=7'h40 (shows "0").
REQ-024 CLR asserted mid-conversion SHALL abort it with no display update; after release, if VAL != 0, a new conversion starts in the first IDLE cycle.
REQ-025 No output SHALL glitch to an undefined value on CLR release.

Verification (REFRESH_BITS=2 in simulation)
REQ-026 Reset with VAL=0 -> BUSY stays 0, digit 0 shows 7'h40, digits 1-3 blank, AN cycles 1110,1101,1011,0111 every 4 cycles.
REQ-027 VAL 0->255 -> BUSY high 9 cycles, 10 edges later HUND/TENS/ONES = 2/5/5, SEG shows 7'h24, 7'h12, 7'h12 on digits 2/1/0.
REQ-028 VAL=7 -> digits 2 and 1 blank, digit 0 = 7'h78; then VAL=40 -> digit 2 blank, digit 1 = 7'h19, digit 0 = 7'h40 (zero shown as non-leading).
REQ-029 VAL 100 -> 101 at 3rd SHIFT cycle -> display shows 1-0-0 after first LATCH, then 1-0-1 after second conversion; BUSY drops for exactly one IDLE cycle between them.
REQ-030 CLR pulsed at 5th SHIFT cycle of VAL=200 -> display shows 0 immediately, after release re-converts and shows 2-0-0.
REQ-031 Exhaustive sweep VAL 0..255 -> each LATCHed BCD equals VAL/100, (VAL/10)%10, VAL%10.
